// File: rtl/br_fifo_pkg.sv
// Shared types for the pseudo-static multi-FIFO: pop-side output buffer
// occupancy encoding and a clog2 helper that never returns zero.
package br_fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

    function automatic int clamped_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/br_arb_rr.sv
// Round-robin arbiter: the grant is the lowest requester at or above the
// priority mask, and the mask advances past the granted lane on update_en_i.
module br_arb_rr #(
    parameter int NumFifos = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumFifos-1:0] req_i,
    input  logic                update_en_i,
    output logic [NumFifos-1:0] grant_o
);

    // An all-ones or all-zeros mask both mean lane 0 has highest priority.
    logic [NumFifos-1:0] mask_q;
    logic [NumFifos-1:0] mask_d;
    logic [NumFifos-1:0] masked_req_s;
    logic [NumFifos-1:0] pick_req_s;

    // Grant the lowest set bit of the masked requests, wrapping to all requests.
    always_comb begin
        masked_req_s = req_i & mask_q;
        if (masked_req_s != '0) begin
            pick_req_s = masked_req_s;
        end else begin
            pick_req_s = req_i;
        end
        grant_o = pick_req_s & (~pick_req_s + NumFifos'(1));
    end

    // Next mask keeps only the lanes strictly above the accepted grant.
    always_comb begin
        if (update_en_i) begin
            mask_d = ~(grant_o | (grant_o - NumFifos'(1)));
        end else begin
            mask_d = mask_q;
        end
    end

    // Priority mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '1;
        end else begin
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/br_fifo_shared_pop_arb_chk.sv
// Protocol checker for br_fifo_shared_pop_arb_rr: one-hot0 ready, output
// stability under backpressure and known data while valid.
module br_fifo_shared_pop_arb_chk #(
    parameter int NumFifos    = 2,
    parameter int Width       = 1,
    parameter int FifoIdWidth = 1
) (
    input logic                   clk,
    input logic                   rst,
    input logic [NumFifos-1:0]    in_ready,
    input logic                   out_valid,
    input logic                   out_ready,
    input logic [Width-1:0]       out_data,
    input logic [FifoIdWidth-1:0] out_fifo_id
);

    a_ready_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(in_ready));

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_fifo_id)));

    a_data_known: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> !$isunknown({out_data, out_fifo_id}));

endmodule

// File: rtl/br_fifo_shared_pop_arb_rr.sv
// Pop-side merge of NumFifos lanes into one stream tagged with the FIFO ID,
// via round-robin arbitration and a 2-entry output buffer. Optional
// starvation watchdog: BR_FIFO_SHARED_POP_ARB_STARVE_WATCHDOG_EN.
module br_fifo_shared_pop_arb_rr
    import br_fifo_pkg::*;
#(
    parameter  int NumFifos        = 2,
    parameter  int Width           = 1,
    parameter  int StarveThreshold = 16,
    localparam int FifoIdWidth     = clamped_clog2(NumFifos)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NumFifos-1:0]            in_valid,
    output logic [NumFifos-1:0]            in_ready,
    input  logic [NumFifos-1:0][Width-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [Width-1:0]               out_data,
    output logic [FifoIdWidth-1:0]         out_fifo_id,
    output logic [NumFifos-1:0]            starve_flag
);

    occ_state_e             state_q, state_d;
    logic [Width-1:0]       head_data_q, head_data_d;
    logic [Width-1:0]       tail_data_q, tail_data_d;
    logic [FifoIdWidth-1:0] head_id_q, head_id_d;
    logic [FifoIdWidth-1:0] tail_id_q, tail_id_d;
    logic                   out_valid_q, out_valid_d;
    logic                   space_s;
    logic                   push_s;
    logic                   pop_s;
    logic [NumFifos-1:0]    grant_s;
    logic [Width-1:0]       sel_data_s;
    logic [FifoIdWidth-1:0] sel_id_s;

    // Reset also blocks accepts so nothing is taken during the reset cycle.
    assign space_s  = (state_q != FULL);
    assign in_ready = grant_s & {NumFifos{space_s & ~rst}};
    assign push_s   = |in_ready;
    assign pop_s    = out_valid_q & out_ready;

    br_arb_rr #(
        .NumFifos (NumFifos)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (in_valid),
        .update_en_i (push_s),
        .grant_o     (grant_s)
    );

    // One-hot AND-OR mux of the granted lane's data and its index.
    always_comb begin
        sel_data_s = '0;
        sel_id_s   = '0;
        for (int i = 0; i < NumFifos; i++) begin
            sel_data_s = sel_data_s | (in_data[i] & {Width{grant_s[i]}});
            sel_id_s   = sel_id_s | (FifoIdWidth'(i) & {FifoIdWidth{grant_s[i]}});
        end
    end

    // Buffer occupancy FSM; the head entry drives the outputs directly.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_id_d   = head_id_q;
        tail_data_d = tail_data_q;
        tail_id_d   = tail_id_q;
        case (state_q)
            EMPTY: begin
                if (push_s) begin
                    head_data_d = sel_data_s;
                    head_id_d   = sel_id_s;
                    state_d     = ONE;
                end else begin
                    state_d = EMPTY;
                end
            end
            ONE: begin
                case ({push_s, pop_s})
                    2'b10: begin
                        tail_data_d = sel_data_s;
                        tail_id_d   = sel_id_s;
                        state_d     = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: begin
                        head_data_d = sel_data_s;
                        head_id_d   = sel_id_s;
                        state_d     = ONE;
                    end
                    default: state_d = ONE;
                endcase
            end
            FULL: begin
                if (pop_s) begin
                    head_data_d = tail_data_q;
                    head_id_d   = tail_id_q;
                    state_d     = ONE;
                end else begin
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        out_valid_d = (state_d != EMPTY);
    end

    // Buffer state and entry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            head_data_q <= '0;
            head_id_q   <= '0;
            tail_data_q <= '0;
            tail_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            head_data_q <= head_data_d;
            head_id_q   <= head_id_d;
            tail_data_q <= tail_data_d;
            tail_id_q   <= tail_id_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = head_data_q;
    assign out_fifo_id = head_id_q;

`ifdef BR_FIFO_SHARED_POP_ARB_STARVE_WATCHDOG_EN
    localparam int                    CntWidth = $clog2(StarveThreshold + 1);
    localparam logic [CntWidth-1:0]   CntMax   = CntWidth'(StarveThreshold);

    logic [NumFifos-1:0][CntWidth-1:0] starve_cnt_q, starve_cnt_d;
    logic [NumFifos-1:0]               starve_flag_q, starve_flag_d;

    // Saturating wait counters; flags stick once a counter hits the limit.
    always_comb begin
        starve_cnt_d  = starve_cnt_q;
        starve_flag_d = starve_flag_q;
        for (int i = 0; i < NumFifos; i++) begin
            starve_flag_d[i] = starve_flag_q[i] | (starve_cnt_q[i] == CntMax);
            if (in_valid[i] && !in_ready[i]) begin
                if (starve_cnt_q[i] != CntMax) begin
                    starve_cnt_d[i] = starve_cnt_q[i] + CntWidth'(1);
                end else begin
                    starve_cnt_d[i] = starve_cnt_q[i];
                end
            end else begin
                starve_cnt_d[i] = '0;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q  <= '0;
            starve_flag_q <= '0;
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            starve_flag_q <= starve_flag_d;
        end
    end

    assign starve_flag = starve_flag_q;
`else
    assign starve_flag = '0;
`endif

endmodule
